// File: rtl/mem_if_pkg.sv
// Shared types and constants for the core-side memory request queue.
// Holds the per-entry lifecycle enum, default widths, the queue depth and
// the request entry layout used by the queue storage.
package mem_if_pkg;

  // Entry lifecycle: FREE -> WAIT_ISSUE -> PENDING (load) / DONE (store)
  // -> DONE (load response) -> FREE (retire).
  typedef enum logic [1:0] {
    FREE       = 2'd0,
    WAIT_ISSUE = 2'd1,
    PENDING    = 2'd2,
    DONE       = 2'd3
  } entry_state_e;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ID_BITS_DEF    = 4;
  localparam int REG_BITS_DEF   = 5;

  // Queue depth: one slot per CREG ID.
  localparam int DEPTH = 2 ** ID_BITS_DEF;

  // Request entry at the default widths (handy for monitors and debug views).
  typedef struct packed {
    logic                      rw;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
    logic [REG_BITS_DEF-1:0]   rd;
    entry_state_e              state;
  } mem_entry_t;

  // Depth for an arbitrary ID width.
  function automatic int depth_of(input int id_bits);
    return 1 << id_bits;
  endfunction

endpackage

// File: rtl/mem_req_slot_ram.sv
// Slot storage for mem_req_queue: one entry per CREG ID.
// Enqueue write port, issue/response/retire state-update ports, and
// asynchronous reads at the issue pointer, the head pointer and the
// response ID. Each slot runs its own small lifecycle FSM.
module mem_req_slot_ram
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_BITS    = 4,
  parameter int REG_BITS   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  // enqueue
  input  logic                  i_wr_en,
  input  logic [ID_BITS-1:0]    i_wr_idx,
  input  logic                  i_wr_rw,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [REG_BITS-1:0]   i_wr_rd,
  // issue
  input  logic                  i_iss_en,
  input  logic [ID_BITS-1:0]    i_iss_idx,
  output entry_state_e          o_iss_state,
  output logic                  o_iss_rw,
  output logic [ADDR_WIDTH-1:0] o_iss_addr,
  output logic [DATA_WIDTH-1:0] o_iss_data,
  // response (caller asserts i_resp_en only for a PENDING slot)
  input  logic                  i_resp_en,
  input  logic [ID_BITS-1:0]    i_resp_idx,
  input  logic [DATA_WIDTH-1:0] i_resp_data,
  output entry_state_e          o_resp_state,
  // retire
  input  logic                  i_ret_en,
  input  logic [ID_BITS-1:0]    i_head_idx,
  output entry_state_e          o_head_state,
  output logic                  o_head_rw,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic [REG_BITS-1:0]   o_head_rd
);

  localparam int SLOTS = depth_of(ID_BITS);

  logic                  r_rw   [SLOTS];
  logic [ADDR_WIDTH-1:0] r_addr [SLOTS];
  logic [DATA_WIDTH-1:0] r_data [SLOTS];
  logic [REG_BITS-1:0]   r_rd   [SLOTS];
  entry_state_e          w_state[SLOTS];

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    entry_state_e r_state;
    entry_state_e w_next_state;

    // Next state of this slot from the event addressed to it.
    // NOTE: hold-value default first so no path leaves the output unassigned (no latch).
    always_comb begin
      w_next_state = r_state;
      case (r_state)
        FREE:       if (i_wr_en  && i_wr_idx   == ID_BITS'(g)) w_next_state = WAIT_ISSUE;
        WAIT_ISSUE: if (i_iss_en && i_iss_idx  == ID_BITS'(g)) w_next_state = r_rw[g] ? DONE : PENDING;
        PENDING:    if (i_resp_en && i_resp_idx == ID_BITS'(g)) w_next_state = DONE;
        DONE:       if (i_ret_en && i_head_idx == ID_BITS'(g)) w_next_state = FREE;
        default:    w_next_state = FREE;
      endcase
    end

    // Slot state register.
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= FREE;
      else        r_state <= w_next_state;
    end

    assign w_state[g] = r_state;
  end

  // Entry payload: written on enqueue, data overwritten by a load response.
  // NOTE: storage is reset deliberately so all mem_*/wb_* outputs read 0 out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_rw[i]   <= 1'b0;
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_rd[i]   <= '0;
      end
    end else begin
      // Enqueue targets a FREE slot, a response a PENDING one: never the same slot.
      if (i_wr_en) begin
        r_rw[i_wr_idx]   <= i_wr_rw;
        r_addr[i_wr_idx] <= i_wr_addr;
        r_data[i_wr_idx] <= i_wr_data;
        r_rd[i_wr_idx]   <= i_wr_rd;
      end
      if (i_resp_en) r_data[i_resp_idx] <= i_resp_data;
    end
  end

  assign o_iss_state  = w_state[i_iss_idx];
  assign o_iss_rw     = r_rw[i_iss_idx];
  assign o_iss_addr   = r_addr[i_iss_idx];
  assign o_iss_data   = r_data[i_iss_idx];

  assign o_resp_state = w_state[i_resp_idx];

  assign o_head_state = w_state[i_head_idx];
  assign o_head_rw    = r_rw[i_head_idx];
  assign o_head_data  = r_data[i_head_idx];
  assign o_head_rd    = r_rd[i_head_idx];

endmodule

// File: rtl/mem_req_queue.sv
// Core-side load/store request queue in front of the L1/dummy memory port.
// Requests are tagged with their slot index as CREG ID, issued in order
// (honouring mem_stall), load responses are captured by ID in any order,
// and entries retire in program order with load data going to writeback.
// Optional: define MEM_REQ_QUEUE_RESP_CHECK_EN to add the sticky resp_err
// output flagging responses that hit a slot not waiting for one.
module mem_req_queue
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_BITS    = ID_BITS_DEF,
  parameter int REG_BITS   = REG_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_rw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [REG_BITS-1:0]   req_rd,
  output logic                  req_ready,
  output logic                  mem_valid,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ID_BITS-1:0]    mem_id,
  input  logic                  mem_stall,
  input  logic                  mem_ready,
  input  logic [ID_BITS-1:0]    mem_resp_id,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [REG_BITS-1:0]   wb_rd,
  input  logic                  wb_ready
`ifdef MEM_REQ_QUEUE_RESP_CHECK_EN
  ,
  output logic                  resp_err
`endif
);

  localparam int               QDEPTH    = depth_of(ID_BITS);
  localparam logic [ID_BITS:0] CNT_FULL  = (ID_BITS+1)'(QDEPTH);
  localparam logic [ID_BITS:0] CNT_ONE   = (ID_BITS+1)'(1);
  localparam logic [ID_BITS-1:0] PTR_ONE = ID_BITS'(1);

  logic [ID_BITS-1:0] r_head;
  logic [ID_BITS-1:0] r_tail;
  logic [ID_BITS-1:0] r_issue;
  logic [ID_BITS:0]   r_count;

  logic                  w_enq;
  logic                  w_retire;
  logic                  w_resp_hit;
  logic                  w_head_done;
  entry_state_e          w_iss_state;
  entry_state_e          w_resp_state;
  entry_state_e          w_head_state;
  logic                  w_iss_rw;
  logic [ADDR_WIDTH-1:0] w_iss_addr;
  logic [DATA_WIDTH-1:0] w_iss_data;
  logic                  w_head_rw;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [REG_BITS-1:0]   w_head_rd;

  // Full is judged from count alone; a retire in the same cycle does not free a slot early.
  assign req_ready = (r_count != CNT_FULL);
  assign w_enq     = req_valid & req_ready;

  // Issue straight from the slot under the issue pointer; its index is the CREG ID.
  assign mem_valid = (w_iss_state == WAIT_ISSUE) & ~mem_stall;
  assign mem_rw    = w_iss_rw;
  assign mem_addr  = w_iss_addr;
  assign mem_data  = w_iss_data;
  assign mem_id    = r_issue;

  // Responses only land on a slot that is actually waiting for one.
  assign w_resp_hit = mem_ready & (w_resp_state == PENDING);

  // Head retire: stores leave on their own, loads wait for writeback to take them.
  assign w_head_done = (w_head_state == DONE);
  assign wb_valid    = w_head_done & ~w_head_rw;
  assign w_retire    = w_head_done & (w_head_rw | wb_ready);
  assign wb_data     = wb_valid ? w_head_data : '0;
  assign wb_rd       = wb_valid ? w_head_rd   : '0;

  mem_req_slot_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ID_BITS    (ID_BITS),
    .REG_BITS   (REG_BITS)
  ) u_slot_ram (
    .clk          (clk),
    .reset        (reset),
    .i_wr_en      (w_enq),
    .i_wr_idx     (r_tail),
    .i_wr_rw      (req_rw),
    .i_wr_addr    (req_addr),
    .i_wr_data    (req_data),
    .i_wr_rd      (req_rd),
    .i_iss_en     (mem_valid),
    .i_iss_idx    (r_issue),
    .o_iss_state  (w_iss_state),
    .o_iss_rw     (w_iss_rw),
    .o_iss_addr   (w_iss_addr),
    .o_iss_data   (w_iss_data),
    .i_resp_en    (w_resp_hit),
    .i_resp_idx   (mem_resp_id),
    .i_resp_data  (mem_resp_data),
    .o_resp_state (w_resp_state),
    .i_ret_en     (w_retire),
    .i_head_idx   (r_head),
    .o_head_state (w_head_state),
    .o_head_rw    (w_head_rw),
    .o_head_data  (w_head_data),
    .o_head_rd    (w_head_rd)
  );

  // Tail, issue and head pointers wrap naturally at 2**ID_BITS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tail  <= '0;
      r_issue <= '0;
      r_head  <= '0;
    end else begin
      if (w_enq)     r_tail  <= r_tail + PTR_ONE;
      if (mem_valid) r_issue <= r_issue + PTR_ONE;
      if (w_retire)  r_head  <= r_head + PTR_ONE;
    end
  end

  // Occupancy: enqueue and retire together leave it unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      case ({w_enq, w_retire})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef MEM_REQ_QUEUE_RESP_CHECK_EN
  logic r_resp_err;

  // Sticky flag for a response that hit a slot not in PENDING.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       r_resp_err <= 1'b0;
    else if (mem_ready & ~w_resp_hit) r_resp_err <= 1'b1;
  end

  assign resp_err = r_resp_err;
`endif

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed self-checking bench for mem_req_queue (default widths).
module tb_mem_req_queue;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_rw;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [4:0]  req_rd;
  logic        req_ready;
  logic        mem_valid;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_id;
  logic        mem_stall;
  logic        mem_ready;
  logic [3:0]  mem_resp_id;
  logic [31:0] mem_resp_data;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_ready;
`ifdef MEM_REQ_QUEUE_RESP_CHECK_EN
  logic        resp_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mem_req_queue dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_rw        (req_rw),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_rd        (req_rd),
    .req_ready     (req_ready),
    .mem_valid     (mem_valid),
    .mem_rw        (mem_rw),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_id        (mem_id),
    .mem_stall     (mem_stall),
    .mem_ready     (mem_ready),
    .mem_resp_id   (mem_resp_id),
    .mem_resp_data (mem_resp_data),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_ready      (wb_ready)
`ifdef MEM_REQ_QUEUE_RESP_CHECK_EN
    ,
    .resp_err      (resp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_data = '0; req_rd = '0;
    mem_stall = 1'b0; mem_ready = 1'b0; mem_resp_id = '0; mem_resp_data = '0;
    wb_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #2;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
    n_cmp++; if ({mem_rw, mem_id, mem_addr, mem_data} !== '0) begin n_bad++; $display("FAIL rst_mem_bus: got id=%h addr=%h data=%h want 0", mem_id, mem_addr, mem_data); end
    n_cmp++; if ({wb_data, wb_rd} !== '0) begin n_bad++; $display("FAIL rst_wb_bus: got data=%h rd=%h want 0", wb_data, wb_rd); end
`ifdef MEM_REQ_QUEUE_RESP_CHECK_EN
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
`endif
    do_reset();
    #1;
    n_cmp++; if (req_ready !== 1'b1 || mem_valid !== 1'b0 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle: got ready=%b mv=%b wv=%b want 1 0 0", req_ready, mem_valid, wb_valid); end
  endtask

  task automatic test_load_alone();
    do_reset();
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h40; req_rd = 5'd3;
    step();                       // accepted into slot 0
    req_valid = 1'b0;
    #1;
    n_cmp++; if (mem_valid !== 1'b1 || mem_id !== 4'd0 || mem_addr !== 32'h40 || mem_rw !== 1'b0) begin n_bad++; $display("FAIL load_issue: got v=%b id=%0d addr=%h rw=%b want 1 0 40 0", mem_valid, mem_id, mem_addr, mem_rw); end
    step();                       // issued
    #1;
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL load_issue_once: got %b want 0", mem_valid); end
    repeat (7) step();
    #1;
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL load_wait_wb: got %b want 0", wb_valid); end
    mem_ready = 1'b1; mem_resp_id = 4'd0; mem_resp_data = 32'hDEADBEEF;
    step();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF || wb_rd !== 5'd3) begin n_bad++; $display("FAIL load_wb: got v=%b data=%h rd=%0d want 1 deadbeef 3", wb_valid, wb_data, wb_rd); end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    #1;
    n_cmp++; if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL load_retired: got wv=%b ready=%b want 0 1", wb_valid, req_ready); end
  endtask

  task automatic test_fill();
    do_reset();
    mem_stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h100 + 32'(4 * i); req_rd = 5'(i);
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_%0d: got %b want 1", i, req_ready); end
      step();
    end
    req_valid = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full: got %b want 0", req_ready); end
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL fill_stalled: got %b want 0", mem_valid); end
    // slot 5 is WAIT_ISSUE: this response must be dropped
    mem_ready = 1'b1; mem_resp_id = 4'd5; mem_resp_data = 32'hBAD00005;
    step();
    mem_ready = 1'b0;
    mem_stall = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_cmp++; if (mem_valid !== 1'b1 || mem_id !== 4'(i) || mem_addr !== 32'h100 + 32'(4 * i)) begin n_bad++; $display("FAIL fill_issue_%0d: got v=%b id=%0d addr=%h want 1 %0d %h", i, mem_valid, mem_id, mem_addr, i, 32'h100 + 32'(4 * i)); end
      step();
    end
    #1;
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL fill_issue_done: got %b want 0", mem_valid); end
    // responses in reverse order; retire must still be in program order
    for (int id = 15; id >= 0; id--) begin
      mem_ready = 1'b1; mem_resp_id = 4'(id); mem_resp_data = 32'h1000 + 32'(id);
      step();
    end
    mem_ready = 1'b0;
    wb_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h1000 + 32'(i) || wb_rd !== 5'(i)) begin n_bad++; $display("FAIL fill_wb_%0d: got v=%b data=%h rd=%0d want 1 %h %0d", i, wb_valid, wb_data, wb_rd, 32'h1000 + 32'(i), i); end
      step();
    end
    wb_ready = 1'b0;
    #1;
    n_cmp++; if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL fill_drained: got wv=%b ready=%b want 0 1", wb_valid, req_ready); end
  endtask

  task automatic test_store_load();
    do_reset();
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h80; req_data = 32'h55; req_rd = '0;
    step();                       // store in slot 0
    req_rw = 1'b0; req_data = '0; req_rd = 5'd7;
    #1;
    n_cmp++; if (mem_valid !== 1'b1 || mem_rw !== 1'b1 || mem_addr !== 32'h80 || mem_data !== 32'h55 || mem_id !== 4'd0) begin n_bad++; $display("FAIL st_issue: got v=%b rw=%b addr=%h data=%h id=%0d want 1 1 80 55 0", mem_valid, mem_rw, mem_addr, mem_data, mem_id); end
    step();                       // load in slot 1, store issued -> DONE
    req_valid = 1'b0;
    #1;
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL st_no_wb: got %b want 0", wb_valid); end
    n_cmp++; if (mem_valid !== 1'b1 || mem_rw !== 1'b0 || mem_id !== 4'd1 || mem_addr !== 32'h80) begin n_bad++; $display("FAIL ld_issue: got v=%b rw=%b id=%0d addr=%h want 1 0 1 80", mem_valid, mem_rw, mem_id, mem_addr); end
    step();                       // store retires, load issued
    #1;
    n_cmp++; if (wb_valid !== 1'b0 || mem_valid !== 1'b0) begin n_bad++; $display("FAIL st_ld_quiet: got wv=%b mv=%b want 0 0", wb_valid, mem_valid); end
    mem_ready = 1'b1; mem_resp_id = 4'd1; mem_resp_data = 32'h55;
    step();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h55 || wb_rd !== 5'd7) begin n_bad++; $display("FAIL ld_wb: got v=%b data=%h rd=%0d want 1 55 7", wb_valid, wb_data, wb_rd); end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    #1;
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL ld_retired: got %b want 0", wb_valid); end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int issued = 0;
    int got = 0;
    int k;
    bit accepted;
    int pend[$];
    do_reset();
    wb_ready = 1'b1;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h1000; req_rd = '0;
    for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
      #1;
      if (mem_valid === 1'b1) begin
        n_cmp++; if (mem_id !== 4'(issued % 16) || mem_addr !== 32'h1000 + 32'(4 * issued)) begin n_bad++; $display("FAIL wrap_issue_%0d: got id=%0d addr=%h want %0d %h", issued, mem_id, mem_addr, issued % 16, 32'h1000 + 32'(4 * issued)); end
        pend.push_back(issued);
        issued++;
      end
      if (wb_valid === 1'b1) begin
        n_cmp++; if (wb_data !== 32'hA5A50000 + 32'(got) || wb_rd !== 5'(got)) begin n_bad++; $display("FAIL wrap_wb_%0d: got data=%h rd=%0d want %h %0d", got, wb_data, wb_rd, 32'hA5A50000 + 32'(got), got % 32); end
        got++;
      end
      accepted = req_valid && req_ready;
      step();
      if (accepted) sent++;
      req_valid = (sent < 40);
      req_addr  = 32'h1000 + 32'(4 * sent);
      req_rd    = 5'(sent);
      if (pend.size() > 0) begin
        k = pend.pop_front();
        mem_ready = 1'b1; mem_resp_id = 4'(k % 16); mem_resp_data = 32'hA5A50000 + 32'(k);
      end else begin
        mem_ready = 1'b0;
      end
    end
    req_valid = 1'b0; mem_ready = 1'b0; wb_ready = 1'b0;
    n_cmp++; if (got != 40 || issued != 40) begin n_bad++; $display("FAIL wrap_count: got wb=%0d issued=%0d want 40 40", got, issued); end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h200; req_rd = 5'd1;
    step();
    req_addr = 32'h204; req_rd = 5'd2;
    step();
    req_valid = 1'b0;
    step();                       // both loads now PENDING
    mem_ready = 1'b1; mem_resp_id = 4'd0; mem_resp_data = 32'h11;
    step();
    mem_resp_id = 4'd1; mem_resp_data = 32'h22;
    step();
    mem_resp_id = 4'd0; mem_resp_data = 32'h77;   // slot 0 already DONE: dropped
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h11 || wb_rd !== 5'd1) begin n_bad++; $display("FAIL bp_hold_%0d: got v=%b data=%h rd=%0d want 1 11 1", i, wb_valid, wb_data, wb_rd); end
      step();
    end
    wb_ready = 1'b1;
    #1;
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h11) begin n_bad++; $display("FAIL bp_first: got v=%b data=%h want 1 11", wb_valid, wb_data); end
    step();
    #1;
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h22 || wb_rd !== 5'd2) begin n_bad++; $display("FAIL bp_second: got v=%b data=%h rd=%0d want 1 22 2", wb_valid, wb_data, wb_rd); end
    step();
    wb_ready = 1'b0;
    #1;
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b want 0", wb_valid); end
  endtask

  task automatic test_stale();
    do_reset();
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h300; req_rd = 5'd4;
    step();
    req_addr = 32'h304; req_rd = 5'd5;
    step();
    req_addr = 32'h308; req_rd = 5'd6;
    step();
    req_valid = 1'b0;
    step();                       // three loads PENDING
    #1;
    n_cmp++; if (mem_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL stale_pre: got mv=%b ready=%b want 0 1", mem_valid, req_ready); end
    reset = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1 || mem_valid !== 1'b0 || wb_valid !== 1'b0 || mem_addr !== 32'h0) begin n_bad++; $display("FAIL stale_async_rst: got ready=%b mv=%b wv=%b addr=%h want 1 0 0 0", req_ready, mem_valid, wb_valid, mem_addr); end
    reset = 1'b1;
    mem_ready = 1'b1; mem_resp_id = 4'd1; mem_resp_data = 32'h99;
    step();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (wb_valid !== 1'b0 || mem_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL stale_ignored: got wv=%b mv=%b ready=%b want 0 0 1", wb_valid, mem_valid, req_ready); end
`ifdef MEM_REQ_QUEUE_RESP_CHECK_EN
    n_cmp++; if (resp_err !== 1'b1) begin n_bad++; $display("FAIL stale_resp_err: got %b want 1", resp_err); end
`endif
    repeat (3) step();
    #1;
    n_cmp++; if (wb_valid !== 1'b0 || wb_data !== 32'h0) begin n_bad++; $display("FAIL stale_quiet: got wv=%b data=%h want 0 0", wb_valid, wb_data); end
  endtask

  initial begin
    test_reset();
    test_load_alone();
    test_fill();
    test_store_load();
    test_wrap();
    test_backpressure();
    test_stale();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
